// File: rtl/motor_pkg.sv
// motor_pkg: definitions shared by the motor start supervisor and the
// reusable motion detector.
//   sup_state_t         - supervisor FSM states
//   ANGLE_W             - rotation-motor angle width
//   DEF_*               - default parameter values
//   sat_inc16/count_hit - saturating counter helpers
package motor_pkg;

  localparam int ANGLE_W = 12;

  localparam logic [ANGLE_W-1:0] DEF_MOVE_THRESH    = 12'd3;
  localparam logic [15:0]        DEF_STALL_CYCLES   = 16'd50000;
  localparam logic [15:0]        DEF_HAMMER_TIMEOUT = 16'd4096;
  localparam logic [15:0]        DEF_BACKOFF_CYCLES = 16'd1024;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START       = 3'd1,
    WAIT_HAMMER = 3'd2,
    RUN         = 3'd3,
    BACKOFF     = 3'd4,
    FAULT       = 3'd5
  } sup_state_t;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // True on the cycle whose increment would make cnt reach lim, so the
  // state changes exactly lim cycles after the counter was cleared.
  function automatic logic count_hit(input logic [15:0] cnt, input logic [15:0] lim);
    return ({1'b0, cnt} + 17'd1) >= {1'b0, lim};
  endfunction

endpackage

// File: rtl/motion_detect.sv
// motion_detect: registered one-cycle motion pulse from angle or hall input.
//   clock, reset_n  - clock, async active-low reset
//   ang_or_drive    - 0: angle mode (current_angle), 1: hall mode (hall_sensor)
//   current_angle   - rotation angle, modulo 2^ANGLE_W
//   hall_sensor     - drive-motor hall input
//   motion          - high for one cycle when motion was seen on the last sample
module motion_detect
  import motor_pkg::*;
#(
  parameter logic [ANGLE_W-1:0] MOVE_THRESH = DEF_MOVE_THRESH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ang_or_drive,
  input  logic [ANGLE_W-1:0] current_angle,
  input  logic               hall_sensor,
  output logic               motion
);

  logic [ANGLE_W-1:0] prev_angle;
  logic               prev_hall;
  logic [ANGLE_W-1:0] delta;
  logic [ANGLE_W-1:0] mag;

  // Modular difference folded to a magnitude so a 4095 -> 2 wrap reads as 3.
  always_comb begin
    delta = current_angle - prev_angle;
    mag   = delta[ANGLE_W-1] ? (-delta) : delta;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_angle <= '0;
      prev_hall  <= 1'b0;
      motion     <= 1'b0;
    end else begin
      prev_angle <= current_angle;
      prev_hall  <= hall_sensor;
      motion     <= ang_or_drive ? (hall_sensor ^ prev_hall) : (mag > MOVE_THRESH);
    end
  end

endmodule

// File: rtl/motor_start_supervisor.sv
// motor_start_supervisor: starts one motor through the hammer block, hands it
// over to the steady-state duty, and supervises it for stalls with bounded
// retries and a sticky fault.
//   clock, reset_n            - clock, async active-low reset
//   enable                    - level, motor commanded on
//   target_pwm, intend_dir    - steady-state duty and direction
//   ang_or_drive              - feedback select (0 angle, 1 hall)
//   current_angle, hall_sensor- feedback inputs
//   retry_count               - retries allowed after the first attempt
//   hammer_done/hammer_error  - hammer result pulses
//   hammer_pwm, hammer_dir    - hammer drive, forwarded while waiting
//   start_motor               - one-cycle start request to the hammer
//   pwm_ratio, pwm_direction  - drive to the PWM generator
//   running, fault, attempts  - status
//   state_dbg                 - current FSM state
//
// Hammer handshake: start_motor is a one-cycle request; the hammer answers with
// a one-cycle hammer_done or hammer_error pulse, which is only honoured while
// in WAIT_HAMMER (error wins when both arrive together). No answer within
// HAMMER_TIMEOUT cycles counts as an error. All outputs are registered from
// the current state, so they trail a state change by one cycle.
module motor_start_supervisor
  import motor_pkg::*;
#(
  parameter logic [15:0]        STALL_CYCLES   = DEF_STALL_CYCLES,
  parameter logic [15:0]        HAMMER_TIMEOUT = DEF_HAMMER_TIMEOUT,
  parameter logic [15:0]        BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
  parameter logic [ANGLE_W-1:0] MOVE_THRESH    = DEF_MOVE_THRESH
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [7:0]         target_pwm,
  input  logic               intend_dir,
  input  logic               ang_or_drive,
  input  logic [ANGLE_W-1:0] current_angle,
  input  logic               hall_sensor,
  input  logic [3:0]         retry_count,
  input  logic               hammer_done,
  input  logic               hammer_error,
  input  logic [7:0]         hammer_pwm,
  input  logic               hammer_dir,
  output logic               start_motor,
  output logic [7:0]         pwm_ratio,
  output logic               pwm_direction,
  output logic               running,
  output logic               fault,
  output logic [3:0]         attempts,
  output sup_state_t         state_dbg
);

  sup_state_t  state_q, state_d;
  logic [15:0] timer_q, timer_d;     // hammer timeout, stall timer or backoff, by state
  logic [3:0]  retries_q, retries_d;
  logic [3:0]  lim_q, lim_d;
  logic [3:0]  attempts_d;
  logic        dir_q, dir_d;         // intend_dir latched at RUN entry
  logic        fail;
  logic        motion;

  logic        start_o, run_o, fault_o, dir_o;
  logic [7:0]  pwm_o;

  motion_detect #(.MOVE_THRESH(MOVE_THRESH)) u_motion (
    .clock         (clock),
    .reset_n       (reset_n),
    .ang_or_drive  (ang_or_drive),
    .current_angle (current_angle),
    .hall_sensor   (hall_sensor),
    .motion        (motion)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      retries_q <= '0;
      lim_q     <= '0;
      attempts  <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      lim_q     <= lim_d;
      attempts  <= attempts_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    retries_d  = retries_q;
    lim_d      = lim_q;
    attempts_d = attempts;
    dir_d      = dir_q;
    fail       = 1'b0;

    case (state_q)
      IDLE: begin
        retries_d  = '0;
        attempts_d = '0;
        if (enable) begin
          lim_d   = retry_count;
          state_d = START;
        end
      end
      START: begin
        attempts_d = (attempts == 4'hF) ? attempts : attempts + 4'd1;
        timer_d    = '0;
        state_d    = WAIT_HAMMER;
      end
      WAIT_HAMMER: begin
        timer_d = sat_inc16(timer_q);
        if (hammer_error || (!hammer_done && count_hit(timer_q, HAMMER_TIMEOUT))) begin
          fail = 1'b1;
        end else if (hammer_done) begin
          timer_d = '0;
          dir_d   = intend_dir;
          state_d = RUN;
        end
      end
      RUN: begin
        if (intend_dir != dir_q) begin
          // A direction change needs a fresh hammer start; it is not a failure.
          retries_d = '0;
          state_d   = START;
        end else if (motion || (target_pwm == 8'd0)) begin
          timer_d = '0;
        end else if (count_hit(timer_q, STALL_CYCLES)) begin
          fail = 1'b1;
        end else begin
          timer_d = sat_inc16(timer_q);
        end
      end
      BACKOFF: begin
        if (count_hit(timer_q, BACKOFF_CYCLES)) begin
          state_d = START;
        end else begin
          timer_d = sat_inc16(timer_q);
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fail) begin
      timer_d = '0;
      if (retries_q < lim_q) begin
        retries_d = retries_q + 4'd1;
        state_d   = BACKOFF;
      end else begin
        state_d = FAULT;
      end
    end

    // Dropping enable overrides everything, including a START not yet issued.
    if (!enable) begin
      state_d    = IDLE;
      timer_d    = '0;
      retries_d  = '0;
      attempts_d = '0;
    end
  end

  always_comb begin
    start_o = 1'b0;
    run_o   = 1'b0;
    fault_o = 1'b0;
    pwm_o   = 8'd0;
    dir_o   = 1'b0;
    if (enable) begin
      case (state_q)
        START:       start_o = 1'b1;
        WAIT_HAMMER: begin
          pwm_o = hammer_pwm;
          dir_o = hammer_dir;
        end
        RUN: begin
          run_o = 1'b1;
          pwm_o = target_pwm;
          dir_o = intend_dir;
        end
        FAULT:       fault_o = 1'b1;
        default:     pwm_o = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_motor   <= 1'b0;
      pwm_ratio     <= 8'd0;
      pwm_direction <= 1'b0;
      running       <= 1'b0;
      fault         <= 1'b0;
    end else begin
      start_motor   <= start_o;
      pwm_ratio     <= pwm_o;
      pwm_direction <= dir_o;
      running       <= run_o;
      fault         <= fault_o;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_motor_start_supervisor.sv
// tb_motor_start_supervisor: scenario tasks for the motor start supervisor.
// Expected attempt numbers are queued before each start is provoked and
// popped by a monitor whenever start_motor pulses.
module tb_motor_start_supervisor;
  import motor_pkg::*;

  localparam logic [15:0] T_STALL = 16'd200;
  localparam logic [15:0] T_HTO   = 16'd128;
  localparam logic [15:0] T_BO    = 16'd32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  target_pwm = 8'd0;
  logic        intend_dir = 1'b0;
  logic        ang_or_drive = 1'b0;
  logic [11:0] current_angle = 12'd0;
  logic        hall_sensor = 1'b0;
  logic [3:0]  retry_count = 4'd0;
  logic        hammer_done = 1'b0;
  logic        hammer_error = 1'b0;
  logic [7:0]  hammer_pwm = 8'd77;
  logic        hammer_dir = 1'b0;
  logic        start_motor;
  logic [7:0]  pwm_ratio;
  logic        pwm_direction;
  logic        running;
  logic        fault;
  logic [3:0]  attempts;
  sup_state_t  state_dbg;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_att;

  int angle_mode = 0;          // 0 hold angle_hold, 1 step +10 every 20, 2 toggle 4095/2
  logic [11:0] angle_hold = 12'd0;
  int ang_tick = 0;
  int hammer_mode = 0;         // 0 silent, 1 done after 100, 2 error, 3 done+error
  int resp_cnt = 0;

  motor_start_supervisor #(
    .STALL_CYCLES   (T_STALL),
    .HAMMER_TIMEOUT (T_HTO),
    .BACKOFF_CYCLES (T_BO),
    .MOVE_THRESH    (12'd3)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .target_pwm    (target_pwm),
    .intend_dir    (intend_dir),
    .ang_or_drive  (ang_or_drive),
    .current_angle (current_angle),
    .hall_sensor   (hall_sensor),
    .retry_count   (retry_count),
    .hammer_done   (hammer_done),
    .hammer_error  (hammer_error),
    .hammer_pwm    (hammer_pwm),
    .hammer_dir    (hammer_dir),
    .start_motor   (start_motor),
    .pwm_ratio     (pwm_ratio),
    .pwm_direction (pwm_direction),
    .running       (running),
    .fault         (fault),
    .attempts      (attempts),
    .state_dbg     (state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  // Angle driver
  always @(negedge clock) begin
    ang_tick = ang_tick + 1;
    case (angle_mode)
      1: if (ang_tick % 20 == 0) current_angle = current_angle + 12'd10;
      2: current_angle = (current_angle == 12'd4095) ? 12'd2 : 12'd4095;
      default: current_angle = angle_hold;
    endcase
  end

  // Hammer model: answers a start request after a mode-dependent delay.
  always @(negedge clock) begin
    hammer_done  = 1'b0;
    hammer_error = 1'b0;
    if (!reset_n) resp_cnt = 0;
    else if (start_motor && hammer_mode != 0) resp_cnt = (hammer_mode == 1) ? 100 : 1;
    if (resp_cnt == 1) begin
      hammer_done  = (hammer_mode == 1 || hammer_mode == 3);
      hammer_error = (hammer_mode == 2 || hammer_mode == 3);
    end
    if (resp_cnt > 0) resp_cnt = resp_cnt - 1;
  end

  // Scoreboard: every start pulse must match the next queued attempt number.
  always @(negedge clock) begin
    if (reset_n && start_motor === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL start_pulse: unexpected start_motor with attempts=%0d, expected no pulse", attempts);
      end else begin
        exp_att = exp_q.pop_front();
        if (attempts !== exp_att) begin
          n_fail++;
          $display("FAIL start_attempts: attempts=%0d expected %0d", attempts, exp_att);
        end
      end
    end
  end

  // Driver: one step lands 1 time unit after a falling edge.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++; if (start_motor !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start_motor); end
    n_checks++; if (pwm_ratio !== 8'd0) begin n_fail++; $display("FAIL reset_pwm: got %0d expected 0", pwm_ratio); end
    n_checks++; if (pwm_direction !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b expected 0", pwm_direction); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
    n_checks++; if (attempts !== 4'd0) begin n_fail++; $display("FAIL reset_attempts: got %0d expected 0", attempts); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_normal_start();
    int k;
    target_pwm = 8'd150; intend_dir = 1'b1; retry_count = 4'd2; ang_or_drive = 1'b0;
    hammer_mode = 1; angle_mode = 1;
    exp_q.push_back(4'd1);
    enable = 1'b1;
    step();
    n_checks++; if (start_motor !== 1'b0) begin n_fail++; $display("FAIL start_early: got %b expected 0", start_motor); end
    step();
    n_checks++; if (start_motor !== 1'b1) begin n_fail++; $display("FAIL start_latency: got %b expected 1", start_motor); end
    step();
    n_checks++; if (start_motor !== 1'b0) begin n_fail++; $display("FAIL start_single: got %b expected 0", start_motor); end
    n_checks++; if (pwm_ratio !== 8'd77) begin n_fail++; $display("FAIL wait_fwd_pwm: got %0d expected 77", pwm_ratio); end
    n_checks++; if (pwm_direction !== 1'b0) begin n_fail++; $display("FAIL wait_fwd_dir: got %b expected 0", pwm_direction); end
    // done is sampled 100 edges after the start pulse, duty shows one edge later
    k = 1;
    while (running !== 1'b1 && k < 400) begin step(); k++; end
    n_checks++; if (k != 101) begin n_fail++; $display("FAIL done_to_run: got %0d cycles expected 101", k); end
    n_checks++; if (pwm_ratio !== 8'd150) begin n_fail++; $display("FAIL run_pwm: got %0d expected 150", pwm_ratio); end
    n_checks++; if (pwm_direction !== 1'b1) begin n_fail++; $display("FAIL run_dir: got %b expected 1", pwm_direction); end
    repeat (600) step();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL run_hold: running=%b expected 1", running); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL run_fault: got %b expected 0", fault); end
    n_checks++; if (attempts !== 4'd1) begin n_fail++; $display("FAIL run_attempts: got %0d expected 1", attempts); end
  endtask

  task automatic test_direction_flip();
    int k;
    exp_q.push_back(4'd2);
    intend_dir = 1'b0;
    step();
    step();
    n_checks++; if (start_motor !== 1'b1) begin n_fail++; $display("FAIL flip_restart: got %b expected 1", start_motor); end
    k = 0;
    while (running !== 1'b1 && k < 400) begin step(); k++; end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL flip_rerun: running=%b expected 1", running); end
    n_checks++; if (pwm_direction !== 1'b0) begin n_fail++; $display("FAIL flip_dir: got %b expected 0", pwm_direction); end
  endtask

  task automatic test_stall_wrap();
    int k;
    int bad;
    angle_hold = 12'd4095; angle_mode = 0;
    step();
    // angle is now 4095: last motion pulse follows the next edge, then only wraps
    angle_mode = 2;
    k = 0;
    while (pwm_ratio !== 8'd0 && k < 1000) begin step(); k++; end
    n_checks++; if (k != int'(T_STALL) + 3) begin n_fail++; $display("FAIL stall_latency: got %0d cycles expected %0d", k, int'(T_STALL) + 3); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stall_running: got %b expected 0", running); end
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL stall_fault: got %b expected 0", fault); end
    exp_q.push_back(4'd3);
    k = 0; bad = 0;
    while (start_motor !== 1'b1 && k < 200) begin
      if (pwm_ratio !== 8'd0) bad++;
      step(); k++;
    end
    n_checks++; if (k != int'(T_BO)) begin n_fail++; $display("FAIL backoff_len: got %0d cycles expected %0d", k, int'(T_BO)); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL backoff_pwm: %0d nonzero samples expected 0", bad); end
    angle_mode = 1;
    k = 0;
    while (running !== 1'b1 && k < 400) begin step(); k++; end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL retry_run: running=%b expected 1", running); end
  endtask

  task automatic test_hammer_errors();
    int k;
    int n;
    int starts[3];
    enable = 1'b0;
    step(); step();
    n_checks++; if (attempts !== 4'd0) begin n_fail++; $display("FAIL idle_attempts: got %0d expected 0", attempts); end
    hammer_mode = 2; retry_count = 4'd2;
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    enable = 1'b1;
    k = 0; n = 0;
    while (fault !== 1'b1 && k < 1000) begin
      step(); k++;
      if (start_motor === 1'b1) begin
        if (n < 3) starts[n] = k;
        n++;
      end
    end
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL err_starts: got %0d pulses expected 3", n); end
    // gap = one WAIT cycle + BACKOFF_CYCLES + the START cycle
    if (n >= 3) begin
      n_checks++; if (starts[1] - starts[0] != int'(T_BO) + 2) begin n_fail++; $display("FAIL err_gap1: got %0d expected %0d", starts[1] - starts[0], int'(T_BO) + 2); end
      n_checks++; if (starts[2] - starts[1] != int'(T_BO) + 2) begin n_fail++; $display("FAIL err_gap2: got %0d expected %0d", starts[2] - starts[1], int'(T_BO) + 2); end
      n_checks++; if (k - starts[2] != 2) begin n_fail++; $display("FAIL err_fault_lat: got %0d expected 2", k - starts[2]); end
    end
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL err_fault: got %b expected 1", fault); end
    n_checks++; if (attempts !== 4'd3) begin n_fail++; $display("FAIL err_attempts: got %0d expected 3", attempts); end
    n_checks++; if (pwm_ratio !== 8'd0) begin n_fail++; $display("FAIL err_pwm: got %0d expected 0", pwm_ratio); end
  endtask

  task automatic test_enable_drop_fault();
    enable = 1'b0;
    step();
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL drop_fault_clear: got %b expected 0", fault); end
    n_checks++; if (pwm_ratio !== 8'd0) begin n_fail++; $display("FAIL drop_fault_pwm: got %0d expected 0", pwm_ratio); end
    repeat (30) step();
    n_checks++; if (attempts !== 4'd0) begin n_fail++; $display("FAIL drop_fault_att: got %0d expected 0", attempts); end
  endtask

  task automatic test_hall_timeout();
    int k;
    ang_or_drive = 1'b1; hammer_mode = 0; retry_count = 4'd0;
    exp_q.push_back(4'd1);
    enable = 1'b1;
    k = 0;
    while (start_motor !== 1'b1 && k < 10) begin step(); k++; end
    n_checks++; if (start_motor !== 1'b1) begin n_fail++; $display("FAIL hto_start: got %b expected 1", start_motor); end
    k = 0;
    while (fault !== 1'b1 && k < 400) begin step(); k++; end
    n_checks++; if (k != int'(T_HTO) + 1) begin n_fail++; $display("FAIL hto_latency: got %0d expected %0d", k, int'(T_HTO) + 1); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_done_and_error();
    int k;
    int saw_run;
    ang_or_drive = 1'b0; hammer_mode = 3; retry_count = 4'd1;
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    enable = 1'b1;
    k = 0; saw_run = 0;
    while (fault !== 1'b1 && k < 1000) begin
      step(); k++;
      if (running === 1'b1) saw_run++;
    end
    n_checks++; if (saw_run != 0) begin n_fail++; $display("FAIL both_ran: running seen %0d cycles expected 0", saw_run); end
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL both_fault: got %b expected 1", fault); end
    n_checks++; if (attempts !== 4'd2) begin n_fail++; $display("FAIL both_attempts: got %0d expected 2", attempts); end
    enable = 1'b0;
    step();
  endtask

  task automatic test_enable_drop_wait();
    int k;
    hammer_mode = 0;
    exp_q.push_back(4'd1);
    enable = 1'b1;
    k = 0;
    while (start_motor !== 1'b1 && k < 10) begin step(); k++; end
    step(); step();
    n_checks++; if (pwm_ratio !== 8'd77) begin n_fail++; $display("FAIL dropw_fwd: got %0d expected 77", pwm_ratio); end
    enable = 1'b0;
    step();
    n_checks++; if (pwm_ratio !== 8'd0) begin n_fail++; $display("FAIL dropw_pwm: got %0d expected 0", pwm_ratio); end
    repeat (300) step();
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL dropw_fault: got %b expected 0", fault); end
    n_checks++; if (attempts !== 4'd0) begin n_fail++; $display("FAIL dropw_att: got %0d expected 0", attempts); end
    // enable for a single cycle: START is entered but its pulse must not appear
    enable = 1'b1;
    step();
    enable = 1'b0;
    k = 0;
    repeat (10) begin step(); if (start_motor === 1'b1) k++; end
    n_checks++; if (k != 0) begin n_fail++; $display("FAIL pending_start: %0d pulses expected 0", k); end
  endtask

  task automatic test_async_reset();
    int k;
    hammer_mode = 1; angle_mode = 1; target_pwm = 8'd150; intend_dir = 1'b1;
    exp_q.push_back(4'd1);
    enable = 1'b1;
    k = 0;
    while (running !== 1'b1 && k < 400) begin step(); k++; end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL ar_run: running=%b expected 1", running); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (pwm_ratio !== 8'd0) begin n_fail++; $display("FAIL ar_pwm: got %0d expected 0", pwm_ratio); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL ar_running: got %b expected 0", running); end
    n_checks++; if (pwm_direction !== 1'b0) begin n_fail++; $display("FAIL ar_dir: got %b expected 0", pwm_direction); end
    n_checks++; if (attempts !== 4'd0) begin n_fail++; $display("FAIL ar_attempts: got %0d expected 0", attempts); end
    n_checks++; if (fault !== 1'b0 || start_motor !== 1'b0) begin n_fail++; $display("FAIL ar_flags: fault=%b start=%b expected 0 0", fault, start_motor); end
    enable = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  // Global time bound
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_normal_start();
    test_direction_flip();
    test_stall_wrap();
    test_hammer_errors();
    test_enable_drop_fault();
    test_hall_timeout();
    test_done_and_error();
    test_enable_drop_wait();
    test_async_reset();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL missing_starts: %0d queued pulses not seen, expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_start_supervisor.md
# motor_start_supervisor

- Initiator and consumer side of the hammer-start handshake.
- On enable, it pulses `start_motor` to the hammer block and forwards the hammer's PWM/direction while the hammer works.
- On `hammer_done`, it hands the motor over to the steady-state duty `target_pwm`.
- While running, it watches the angle or hall feedback for stalls. Stalls and hammer failures trigger bounded retries with a cooldown; when retries run out, a sticky `fault` is raised.
- Sits between the swerve-module command registers and the hammer/PWM path, one instance per motor.

## Interface
- `STALL_CYCLES`, default 50000 — RUN cycles with no detected motion before a stall is declared (16-bit).
- `HAMMER_TIMEOUT`, default 4096 — maximum cycles in WAIT_HAMMER before an implicit hammer failure (16-bit).
- `BACKOFF_CYCLES`, default 1024 — zero-PWM cooldown between attempts (16-bit).
- `MOVE_THRESH`, default 3 — minimum angle step magnitude, exclusive, that counts as motion.
- `clock` in 1 — main clock.
- `reset_n` in 1 — asynchronous reset, active low.
- `enable` in 1 — level; motor commanded on.
- `target_pwm` in 8 — steady-state duty used in RUN.
- `intend_dir` in 1 — commanded direction.
- `ang_or_drive` in 1 — 0 = use `current_angle`, 1 = use `hall_sensor`.
- `current_angle` in 12 — rotation-motor angle.
- `hall_sensor` in 1 — drive-motor hall input.
- `retry_count` in 4 — number of retries allowed after the first attempt.
- `hammer_done` in 1 — hammer succeeded (pulse).
- `hammer_error` in 1 — hammer failed (pulse).
- `hammer_pwm` in 8 — hammer duty.
- `hammer_dir` in 1 — hammer direction.
- `start_motor` out 1 — single-cycle request to the hammer.
- `pwm_ratio` out 8 — duty to the PWM generator.
- `pwm_direction` out 1 — direction to the PWM generator.
- `running` out 1 — high in RUN.
- `fault` out 1 — sticky failure flag.
- `attempts` out 4 — attempts started since leaving IDLE, saturating at 15.

## Operation
States: IDLE, START, WAIT_HAMMER, RUN, BACKOFF, FAULT.

**IDLE**
- `retries_used` = 0, `attempts` = 0.
- On `enable`: latch `retry_count` into `retry_lim`, then go to START.

**START**
- Assert `start_motor` for exactly one cycle and increment `attempts`.
- Next state: WAIT_HAMMER, with the timeout counter cleared.

**WAIT_HAMMER**
- Forward `hammer_pwm` / `hammer_dir`.
- `hammer_done` → RUN, with the stall timer cleared.
- `hammer_error` or timeout reaching `HAMMER_TIMEOUT` → FAIL path.
- If `hammer_done` and `hammer_error` arrive in the same cycle, error wins.

**RUN**
- Output `target_pwm` / `intend_dir`.
- The stall timer clears on every motion pulse and increments otherwise.
- When `target_pwm` == 0 the stall timer is held at 0.
- Timer reaching `STALL_CYCLES` → FAIL path.
- An `intend_dir` change relative to the value latched at RUN entry → START, with `retries_used` cleared.

**FAIL path**
- If `retries_used` < `retry_lim`: increment `retries_used`, go to BACKOFF.
- Otherwise go to FAULT.

**BACKOFF**
- PWM 0 for `BACKOFF_CYCLES`, then START.

**FAULT**
- PWM 0, `fault` = 1.
- Leaves only when `enable` falls, going to IDLE with `fault` cleared.

**General rules**
- `enable` low in any state → IDLE next cycle, PWM 0. A pending START pulse is not issued.
- `hammer_done` / `hammer_error` outside WAIT_HAMMER are ignored.
- Motion detection uses a 1-cycle registered sample of the previous angle/hall value.
- Angle mode: `d` = `current_angle` − `prev` (mod 4096); `|d|` = `d[11]` ? −`d` : `d`; motion when `|d|` > `MOVE_THRESH`. The wrap from 4095 to 2 gives `|d|` = 3, which is not motion.
- Hall mode: any edge is motion.

## Timing
- All outputs are registered.
- Reset values: every output 0, including `pwm_direction`; state IDLE.
- `enable` rising → `start_motor` high 2 cycles later (IDLE→START, then the registered output).
- `hammer_done` → RUN duty visible on `pwm_ratio` 2 cycles later.
- Stall: `fault` or a BACKOFF PWM of 0 appears `STALL_CYCLES` + 2 cycles after the last motion pulse.
- BACKOFF → `start_motor` after `BACKOFF_CYCLES` + 1 cycles.
- All counters are 16-bit and saturate; none wrap.
- Reset asserted mid-operation clears everything asynchronously. No `start_motor` is emitted during reset.

## Structure
- Shared package `motor_pkg`: state enum `sup_state_t`, default constants for `MOVE_THRESH`, `STALL_CYCLES` and `HAMMER_TIMEOUT`, and the 12-bit angle width.
- One sub-module, `motion_detect`: angle/hall inputs plus mode → a registered 1-cycle `motion` pulse. It can be reused by other speed-monitoring blocks.

## Test plan
- `enable` = 1, `retry_count` = 2, hammer returns `hammer_done` 100 cycles after `start_motor`, angle steps by 10 every 20 cycles → exactly one `start_motor`, `running` = 1, `pwm_ratio` = `target_pwm` (e.g. 150), `fault` = 0.
- `hammer_error` on every attempt, `retry_count` = 2 → three `start_motor` pulses, each separated by `BACKOFF_CYCLES` of PWM 0, then `fault` = 1, `attempts` = 3.
- RUN with `ang_or_drive` = 0, angle frozen at 4095 then toggling between 4095 and 2 → stall declared after `STALL_CYCLES` (wrap treated as no motion), retry issued.
- Hall mode, hammer never responds → implicit failure at `HAMMER_TIMEOUT`; `hammer_done` and `hammer_error` in the same cycle → treated as error.
- `enable` dropped in WAIT_HAMMER and in FAULT → PWM 0 next cycle, `fault` cleared, no further `start_motor` pulses.
- `intend_dir` flipped in RUN → a new `start_motor` with `retries_used` reset; async reset mid-RUN → all outputs 0 immediately.
